// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch/issue sequencer: imem req/ack fetch, IR hold, next-PC select.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TMO_CYC  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [3:0]      opcode,
  output logic [15:0]     instr,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic [1:0]      pc_sel,
  input  logic [PC_W-1:0] br_tgt,
  input  logic [PC_W-1:0] jmp_tgt,
  input  logic [PC_W-1:0] reg_tgt,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            halted,
  output logic            fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_UNDEF = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HLT   = 4'hF;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_tgt;
  logic [3:0]      ir_op;
  logic            tmo_hit;

  assign pc_inc = pc_q + PC_W'(1);
  assign ir_op  = ir_q[15:12];

  always_comb begin
    pc_tgt = pc_inc;
    unique case (pc_sel)
      2'b00: pc_tgt = pc_inc;
      2'b01: pc_tgt = br_tgt;
      2'b10: pc_tgt = jmp_tgt;
      2'b11: pc_tgt = reg_tgt;
      default: pc_tgt = pc_inc;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Count resets whenever we are outside FETCH, so each fetch starts at 0
  assign tmo_hit = (cnt_q == CW'(TMO_CYC - 1));

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (state_q == S_FETCH && !imem_ack) begin
      cnt_d = cnt_q + CW'(1);
      if (tmo_hit) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign fetch_err  = 1'b0;
  assign unused_tmo = ^TMO_CYC;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_ISSUE;
        end else if (tmo_hit) begin
          state_d = S_HALT;
        end
      end
      S_ISSUE: begin
        if (ir_op == OP_HLT) begin
          state_d = S_HALT;
        end else if (ir_op == OP_UNDEF || ir_op == OP_NOP) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else if (exec_done) begin
          pc_d    = pc_tgt;
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'hE000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Reset gates the handshake combinationally so req drops immediately
  assign imem_req    = rst_n && (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = rst_n && (state_q == S_ISSUE);
  assign opcode      = instr_valid ? ir_op : OP_NOP;
  assign instr       = ir_q;
  assign pc          = pc_q;
  assign pc_plus1    = pc_inc;
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer with randomized
// instruction streams against a behavioural next-PC model.
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        exec_done = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [7:0]  br_tgt = 8'h0;
  logic [7:0]  jmp_tgt = 8'h0;
  logic [7:0]  reg_tgt = 8'h0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [3:0]  opcode;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic [7:0]  pc_plus1;
  logic        halted;
  logic        fetch_err;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_pc;

  instr_fetch_sequencer #(
    .PC_W(8),
    .RESET_PC(8'h10),
    .TMO_CYC(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .opcode(opcode),
    .instr(instr),
    .instr_valid(instr_valid),
    .exec_done(exec_done),
    .pc_sel(pc_sel),
    .br_tgt(br_tgt),
    .jmp_tgt(jmp_tgt),
    .reg_tgt(reg_tgt),
    .pc(pc),
    .pc_plus1(pc_plus1),
    .halted(halted),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_next(input logic [3:0] op,
    input logic [1:0] sel, input logic [7:0] p,
    input logic [7:0] b, input logic [7:0] j, input logic [7:0] r);
    int nxt;
    if (op == 4'd13 || op == 4'd14) nxt = (int'(p) + 1) % 256;
    else if (sel == 2'd0) nxt = (int'(p) + 1) % 256;
    else if (sel == 2'd1) nxt = int'(b);
    else if (sel == 2'd2) nxt = int'(j);
    else nxt = int'(r);
    return nxt[7:0];
  endfunction

  // Called at a negedge; leaves the bench at a negedge with the DUT reset.
  task automatic test_reset();
    imem_ack = 1'b0;
    exec_done = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b0 || opcode !== 4'hE) begin
      fails++;
      $display("FAIL reset_comb: req=%b op=%h want req=0 op=e", imem_req, opcode);
    end
    @(negedge clk);
    tests++;
    if (pc !== 8'h10 || instr !== 16'hE000 || halted !== 1'b0 ||
        fetch_err !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: pc=%h ir=%h h=%b e=%b req=%b v=%b want 10 e000 0 0 0 0",
               pc, instr, halted, fetch_err, imem_req, instr_valid);
    end
    rst_n = 1'b1;
    exp_pc = 8'h10;
    #1;
  endtask

  task automatic fetch_word(input logic [15:0] w, input int lat);
    for (int i = 0; i <= lat; i++) begin
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc !== exp_pc) begin
        fails++;
        $display("FAIL fetch_addr: req=%b addr=%h pc=%h want req=1 addr=%h",
                 imem_req, imem_addr, pc, exp_pc);
      end
      tests++;
      if (opcode !== 4'hE || instr_valid !== 1'b0 ||
          pc_plus1 !== 8'((int'(exp_pc) + 1) % 256)) begin
        fails++;
        $display("FAIL fetch_out: op=%h v=%b pc1=%h want op=e v=0 pc1=%h",
                 opcode, instr_valid, pc_plus1, 8'((int'(exp_pc) + 1) % 256));
      end
      exec_done = 1'($urandom_range(0, 1));
      pc_sel = 2'($urandom);
      imem_ack = (i == lat);
      imem_rdata = (i == lat) ? w : 16'($urandom);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    exec_done = 1'b0;
  endtask

  task automatic issue_word(input logic [15:0] w, input int lat,
    input logic [1:0] sel, input logic [7:0] b, input logic [7:0] j,
    input logic [7:0] r);
    logic [3:0] op;
    int n;
    op = w[15:12];
    n = (op == 4'd13 || op == 4'd14) ? 0 : lat;
    br_tgt = b;
    jmp_tgt = j;
    reg_tgt = r;
    for (int i = 0; i <= n; i++) begin
      tests++;
      if (instr_valid !== 1'b1 || opcode !== op || instr !== w ||
          imem_req !== 1'b0) begin
        fails++;
        $display("FAIL issue: v=%b op=%h ir=%h req=%b want v=1 op=%h ir=%h req=0",
                 instr_valid, opcode, instr, imem_req, op, w);
      end
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      if (op == 4'd13 || op == 4'd14) begin
        exec_done = 1'($urandom_range(0, 1));
        pc_sel = 2'($urandom);
      end else begin
        exec_done = (i == n);
        pc_sel = (i == n) ? sel : 2'($urandom);
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    exec_done = 1'b0;
    exp_pc = model_next(op, sel, exp_pc, b, j, r);
  endtask

  task automatic test_first_fetch();
    fetch_word(16'h0123, 0);
    issue_word(16'h0123, 2, 2'b00, 8'hAA, 8'hBB, 8'hCC);
  endtask

  task automatic test_branches();
    fetch_word(16'h9ABC, 1);
    issue_word(16'h9ABC, 0, 2'b01, 8'h40, 8'h11, 8'h22);
    fetch_word(16'h3456, 2);
    issue_word(16'h3456, 1, 2'b11, 8'h33, 8'h44, 8'h07);
    tests++;
    if (exp_pc !== 8'h07 || imem_addr !== 8'h07) begin
      fails++;
      $display("FAIL jr_target: addr=%h model=%h want 07", imem_addr, exp_pc);
    end
  endtask

  task automatic test_wrap();
    fetch_word(16'hB000, 0);
    issue_word(16'hB000, 0, 2'b10, 8'h00, 8'hFF, 8'h00);
    fetch_word(16'hE000, 0);
    issue_word(16'hE000, 0, 2'b10, 8'h55, 8'h66, 8'h77);
    tests++;
    if (pc !== 8'h00 || imem_addr !== 8'h00 || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL pc_wrap: pc=%h addr=%h req=%b want 00 00 1", pc, imem_addr, imem_req);
    end
  endtask

  task automatic test_random(input int count);
    for (int k = 0; k < count; k++) begin
      logic [15:0] w;
      w = {4'($urandom_range(0, 14)), 12'($urandom)};
      fetch_word(w, $urandom_range(0, 3));
      issue_word(w, $urandom_range(0, 3), 2'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_halt();
    logic [7:0] hpc;
    hpc = exp_pc;
    fetch_word(16'hF000, 1);
    tests++;
    if (instr_valid !== 1'b1 || opcode !== 4'hF) begin
      fails++;
      $display("FAIL hlt_issue: v=%b op=%h want v=1 op=f", instr_valid, opcode);
    end
    exec_done = 1'b1;
    pc_sel = 2'b10;
    jmp_tgt = 8'h55;
    @(negedge clk);
    exec_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          opcode !== 4'hE || pc !== hpc) begin
        fails++;
        $display("FAIL halt_hold: h=%b req=%b v=%b op=%h pc=%h want 1 0 0 e %h",
                 halted, imem_req, instr_valid, opcode, pc, hpc);
      end
      imem_ack = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    test_reset();
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 15; i++) @(negedge clk);
    tests++;
    if (fetch_err !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL tmo_early: err=%b h=%b req=%b want 0 0 1", fetch_err, halted, imem_req);
    end
    @(negedge clk);
    tests++;
    if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL tmo_trip: err=%b h=%b req=%b want 1 1 0", fetch_err, halted, imem_req);
    end
    test_reset();
    fetch_word(16'h4321, 15);
    tests++;
    if (fetch_err !== 1'b0 || instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL tmo_ack_wins: err=%b v=%b want 0 1", fetch_err, instr_valid);
    end
    test_reset();
  endtask
`endif

  initial begin
    exp_pc = 8'h10;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_branches();
    test_wrap();
    test_reset();
    test_random(150);
    test_halt();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_random(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
